// File: rtl/seg4x7_capture.sv
// ============================================================================
// Module   : seg4x7_capture
// Brief    : Reconstructs a 4-digit hex value from a multiplexed 7-segment bus.
//            Optional macro SEG_CAPTURE_DP_EN captures per-digit decimal points.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seg4x7_capture #(
    parameter int SETTLE_CYCLES    = 64,
    parameter int TIMEOUT_CYCLES   = 2000000,
    parameter bit DIGIT_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  digit_sel,
    input  logic [7:0]  seg,
    output logic [15:0] value,
    output logic [3:0]  digit_err,
    output logic [3:0]  dp,
    output logic        frame_stb,
    output logic        stale
);

    localparam int c_SW = $clog2(SETTLE_CYCLES) + 1;
    localparam int c_TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [c_SW-1:0] c_SETTLE_MAX  = c_SW'(SETTLE_CYCLES);
    localparam logic [c_SW-1:0] c_SETTLE_FIRE = c_SW'(SETTLE_CYCLES - 1);
    localparam logic [c_TW-1:0] c_TIMEOUT_MAX = c_TW'(TIMEOUT_CYCLES);

    typedef enum logic [0:0] {
        S_COLLECT = 1'b0,
        S_PUBLISH = 1'b1
    } state_t;

    // Returns {err, code}; the dp bit never takes part in the decode.
    function automatic logic [4:0] f_decode(input logic [6:0] i_pat);
        logic [4:0] v;
        case (i_pat)
            7'h3F: v = 5'h00;  7'h06: v = 5'h01;  7'h5B: v = 5'h02;  7'h4F: v = 5'h03;
            7'h66: v = 5'h04;  7'h6D: v = 5'h05;  7'h7D: v = 5'h06;  7'h07: v = 5'h07;
            7'h7F: v = 5'h08;  7'h6F: v = 5'h09;  7'h77: v = 5'h0A;  7'h7C: v = 5'h0B;
            7'h39: v = 5'h0C;  7'h5E: v = 5'h0D;  7'h79: v = 5'h0E;  7'h71: v = 5'h0F;
            default: v = 5'h10;
        endcase
        return v;
    endfunction

    logic [3:0]      r_sel_m, r_sel_s;
    logic [7:0]      r_seg_m, r_seg_s;
    logic [11:0]     r_prev;
    logic [c_SW-1:0] r_settle;
    logic [c_TW-1:0] r_timeout;
    logic [3:0]      r_seen;
    logic [15:0]     r_val_sh;
    logic [3:0]      r_err_sh;
    logic [15:0]     r_value;
    logic [3:0]      r_err;
    logic            r_frame_stb;
    logic            r_stale;
    state_t          r_state, w_state_nxt;

    logic [3:0]  w_sel;
    logic [7:0]  w_seg;
    logic [11:0] w_cur;
    logic        w_same;
    logic        w_onehot;
    logic        w_acc;
    logic [4:0]  w_dec;
    logic [3:0]  w_seen_upd;

    assign w_sel    = DIGIT_ACTIVE_LOW ? ~r_sel_s : r_sel_s;
    assign w_seg    = SEG_ACTIVE_LOW   ? ~r_seg_s : r_seg_s;
    assign w_cur    = {w_sel, w_seg};
    assign w_same   = (w_cur == r_prev);
    assign w_onehot = (w_sel != 4'b0000) && ((w_sel & (w_sel - 4'd1)) == 4'b0000);
    assign w_acc    = w_same && (r_settle == c_SETTLE_FIRE) && w_onehot;
    assign w_dec    = f_decode(w_seg[6:0]);
    assign w_seen_upd = r_seen | (w_acc ? w_sel : 4'b0000);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_m  <= '0;
            r_sel_s  <= '0;
            r_seg_m  <= '0;
            r_seg_s  <= '0;
            r_prev   <= '0;
            r_settle <= '0;
        end else begin
            r_sel_m  <= digit_sel;
            r_sel_s  <= r_sel_m;
            r_seg_m  <= seg;
            r_seg_s  <= r_seg_m;
            r_prev   <= w_cur;
            if (!w_same)
                r_settle <= '0;
            else if (r_settle != c_SETTLE_MAX)
                r_settle <= r_settle + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_COLLECT;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_COLLECT: if (w_seen_upd == 4'b1111) w_state_nxt = S_PUBLISH;
            S_PUBLISH: w_state_nxt = S_COLLECT;
            default:   w_state_nxt = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seen      <= '0;
            r_val_sh    <= '0;
            r_err_sh    <= '0;
            r_value     <= '0;
            r_err       <= '0;
            r_frame_stb <= 1'b0;
            r_stale     <= 1'b1;
            r_timeout   <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc && w_sel[i]) begin
                    r_val_sh[4*i +: 4] <= w_dec[3:0];
                    r_err_sh[i]        <= w_dec[4];
                end
            end

            if (w_acc)
                r_timeout <= '0;
            else if (r_timeout != c_TIMEOUT_MAX)
                r_timeout <= r_timeout + 1'b1;

            // Outputs take the pre-edge shadow, so a digit accepted now belongs to the next frame.
            if (r_state == S_PUBLISH) begin
                r_seen      <= w_acc ? w_sel : 4'b0000;
                r_value     <= r_val_sh;
                r_err       <= r_err_sh;
                r_frame_stb <= 1'b1;
                r_stale     <= 1'b0;
            end else begin
                r_seen      <= w_seen_upd;
                r_frame_stb <= 1'b0;
                if (r_timeout == c_TIMEOUT_MAX)
                    r_stale <= 1'b1;
            end
        end
    end

`ifdef SEG_CAPTURE_DP_EN
    logic [3:0] r_dp_sh;
    logic [3:0] r_dp;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dp_sh <= '0;
            r_dp    <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc && w_sel[i])
                    r_dp_sh[i] <= w_seg[7];
            end
            if (r_state == S_PUBLISH)
                r_dp <= r_dp_sh;
        end
    end

    assign dp = r_dp;
`else
    assign dp = 4'b0000;
`endif

    assign value     = r_value;
    assign digit_err = r_err;
    assign frame_stb = r_frame_stb;
    assign stale     = r_stale;

endmodule

`default_nettype wire

// File: tb/tb_seg4x7_capture.sv
// ============================================================================
// Module   : tb_seg4x7_capture
// Brief    : Scoreboard bench for seg4x7_capture; directed digit rotations.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seg4x7_capture;

    localparam int c_SETTLE  = 64;
    localparam int c_TIMEOUT = 1000;
`ifdef SEG_CAPTURE_DP_EN
    localparam logic [3:0] c_DP_EXP = 4'b0001;
`else
    localparam logic [3:0] c_DP_EXP = 4'b0000;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  digit_sel;
    logic [7:0]  seg;
    logic [15:0] value;
    logic [3:0]  digit_err;
    logic [3:0]  dp;
    logic        frame_stb;
    logic        stale;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  e;
        logic [3:0]  d;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    seg4x7_capture #(
        .SETTLE_CYCLES   (c_SETTLE),
        .TIMEOUT_CYCLES  (c_TIMEOUT),
        .DIGIT_ACTIVE_LOW(1'b1),
        .SEG_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .digit_sel(digit_sel),
        .seg      (seg),
        .value    (value),
        .digit_err(digit_err),
        .dp       (dp),
        .frame_stb(frame_stb),
        .stale    (stale)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // glyph is active-high {dp,g..a}; the bus is active-low on both sel and seg
    task automatic show(input int slot, input logic [7:0] glyph, input int hold);
        logic [3:0] one;
        one       = 4'b0001;
        digit_sel = ~(one << slot);
        seg       = ~glyph;
        repeat (hold) @(posedge clk);
    endtask

    task automatic rotate(input logic [7:0] g0, input logic [7:0] g1,
                          input logic [7:0] g2, input logic [7:0] g3);
        show(0, g0, 200);
        show(1, g1, 200);
        show(2, g2, 200);
        show(3, g3, 200);
    endtask

    always @(negedge clk) begin
        if (!reset && frame_stb) begin
            if (q.size() == 0) begin
                chk("unexpected_frame_stb", {31'b0, frame_stb}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("frame_value", {16'b0, value}, {16'b0, e.v});
                chk("frame_err",   {28'b0, digit_err}, {28'b0, e.e});
                chk("frame_dp",    {28'b0, dp}, {28'b0, e.d});
                chk("frame_stale", {31'b0, stale}, 32'd0);
            end
        end
    end

    initial begin
        int budget;
        reset     = 1'b1;
        digit_sel = 4'hF;
        seg       = 8'hFF;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_value", {16'b0, value}, 32'd0);
        chk("rst_err",   {28'b0, digit_err}, 32'd0);
        chk("rst_dp",    {28'b0, dp}, 32'd0);
        chk("rst_stb",   {31'b0, frame_stb}, 32'd0);
        chk("rst_stale", {31'b0, stale}, 32'd1);
        @(posedge clk);
        reset = 1'b0;

        // Digits 1,2,3,4 in slots 0..3
        q.push_back('{16'h4321, 4'b0000, 4'b0000});
        rotate(8'h06, 8'h5B, 8'h4F, 8'h66);

        // Blank glyph in slot 2
        q.push_back('{16'h0000, 4'b0100, 4'b0000});
        rotate(8'h3F, 8'h3F, 8'h00, 8'h3F);

        // Multi-hot select ignored, then A,b,C,d
        digit_sel = 4'b1100;
        seg       = ~8'h3F;
        repeat (500) @(posedge clk);
        q.push_back('{16'hDCBA, 4'b0000, 4'b0000});
        rotate(8'h77, 8'h7C, 8'h39, 8'h5E);

        // Reset after three digits aborts the frame
        show(0, 8'h6D, 200);
        show(1, 8'h7D, 200);
        show(2, 8'h07, 200);
        show(3, 8'h7F, 0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_value", {16'b0, value}, 32'd0);
        chk("abort_stale", {31'b0, stale}, 32'd1);
        @(posedge clk);
        reset = 1'b0;
        repeat (200) @(posedge clk);
        // Slot 3 (8) was seen after reset; slots 0..2 complete that frame
        q.push_back('{16'h8BA9, 4'b0000, 4'b0000});
        show(0, 8'h6F, 200);
        show(1, 8'h77, 200);
        show(2, 8'h7C, 200);

        // Glitching digits never settle: no strobe, stale rises after timeout
        for (int r = 0; r < 6; r++) begin
            for (int s = 0; s < 4; s++) begin
                show(s, 8'h06, c_SETTLE - 1);
                if (r == 0 && s == 0) begin
                    @(negedge clk);
                    chk("glitch_stale_early", {31'b0, stale}, 32'd0);
                end
            end
        end
        @(negedge clk);
        chk("glitch_stale_late", {31'b0, stale}, 32'd1);

        // Decimal point lit on slot 0
        q.push_back('{16'h0001, 4'b0000, c_DP_EXP});
        rotate(8'h86, 8'h3F, 8'h3F, 8'h3F);

        budget = 0;
        while (q.size() != 0 && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        chk("pending_frames", q.size(), 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seg4x7_capture.md
Name: seg4x7_capture

Overview:
- Reader for the multiplexed 4-digit 7-segment bus: digit_sel[3:0] plus segment byte {dp,g,f,e,d,c,b,a}.
- Observes the bus the display driver produces and reconstructs the displayed hex value, one 4-bit code per digit.
- Sits on shield IO inputs, or loops back on the driver's internal wires for self-test.
- Publishes a 16-bit value plus per-digit error flags once every digit has been seen in a frame.

Parameters:
- SETTLE_CYCLES, 64: consecutive cycles digit_sel and segments must be unchanged before a digit is sampled.
- TIMEOUT_CYCLES, 2000000: cycles without any accepted digit before stale asserts.
- DIGIT_ACTIVE_LOW, 1: 1 = digit_sel bit low selects that digit.
- SEG_ACTIVE_LOW, 1: 1 = segment bit low means segment lit.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- digit_sel  in  4  sampled digit strobes; bit i selects slot i
- seg  in  8  sampled segments {dp,g,f,e,d,c,b,a}
- value  out  16  decoded digits; slot i at value[4i+3:4i]
- digit_err  out  4  bit i = slot i pattern not a hex glyph
- dp  out  4  decimal points per slot (see Optional Feature)
- frame_stb  out  1  one-cycle pulse when value/digit_err/dp update
- stale  out  1  no valid digit accepted for TIMEOUT_CYCLES

Behaviour:
- Reset values: value=0, digit_err=0, dp=0, frame_stb=0, stale=1, internal seen mask=0, settle counter=0, timeout counter=0.
- Reset is honoured in any cycle and aborts a partial frame.
- Input conditioning:
  - Two-flop synchronizer on all 12 inputs.
  - Then polarity normalise to active-high per DIGIT_ACTIVE_LOW and SEG_ACTIVE_LOW.
- Settle counter:
  - Clears whenever normalised {sel,seg} differs from the previous cycle.
  - Otherwise increments, saturating at SETTLE_CYCLES.
  - Accept strobe fires exactly once, on the cycle the counter reaches SETTLE_CYCLES-1 with unchanged inputs.
  - Latency from input change to accept: 2 (sync) + SETTLE_CYCLES cycles.
- Accept qualification: sel must be one-hot. 0000 or multi-hot is ignored: no capture, and the timeout counter is not reset.
- Decode table (active-high {g..a}):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Any other pattern → code 0, err=1.
- Capture into a shadow slot i:
  - Store code, err and dp for slot i; set seen[i].
  - Recapturing an already-seen slot overwrites the shadow.
- FSM, two states:
  - COLLECT: capture as above. When seen becomes 1111 (including via the capture in that same cycle), go to PUBLISH.
  - PUBLISH: copy shadow to outputs, pulse frame_stb for one cycle, clear seen, return to COLLECT next cycle.
  - An accept that lands in the PUBLISH cycle is captured into the new frame (seen starts with that bit).
- Timeout counter:
  - Resets to 0 on each accepted one-hot digit.
  - Otherwise increments, saturating at TIMEOUT_CYCLES.
  - stale=1 while saturated; stale clears on the frame_stb cycle.
  - Outputs hold their last frame while stale.
- Counter widths are $clog2 of their parameter + 1. No wrap.

Optional Feature:
- Macro SEG_CAPTURE_DP_EN.
- Defined: the dp bit is captured per slot and published on dp[3:0].
- Undefined: dp is tied to 0, dp shadow flops are removed, and the decode ignores the dp bit (as it does in both builds).

Test Plan:
- Reset, then drive sel cycling 1110,1101,1011,0111 with seg active-low for 1,2,3,4, each held 200 cycles → one frame_stb; value=16'h4321, digit_err=0, stale falls with the strobe.
- Slot 2 shows glyph 0x00 (blank) with others showing 0,0,0 → value=16'h0000, digit_err=4'b0100.
- Glitch: each digit held only SETTLE_CYCLES-1 cycles → no frame_stb ever; stale rises after TIMEOUT_CYCLES (bench uses TIMEOUT_CYCLES=1000).
- Multi-hot sel 1100 for 500 cycles between normal digits → ignored; next full rotation of A,b,C,d publishes value=16'hdCbA.
- Reset asserted after 3 of 4 digits captured, then 4th digit only → no frame_stb until a full new rotation completes.
- With SEG_CAPTURE_DP_EN: slot 0 dp lit → dp=4'b0001. Without the macro, the same stimulus gives dp=0.
